tt_um_guihca_scope: RTL and testbench

Tiny Tapeout user tile and the successor to the switch-adder tile. It keeps the registered add mode, in which the 7-segment port shows switches plus the bidirectional bus. It adds a parametrised serial capture buffer: an armed strobe records a bit stream from one switch, and the result plays back one byte at a time on the display at a human-visible rate. The block sits directly under the Tiny Tapeout harness and uses the standard `tt_um_*` port list.

---
 rtl/tt_um_guihca_scope.sv | 140 ++++++++++++++
 tb/tb_tt_um_guihca_scope.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tt_um_guihca_scope.sv
// ============================================================================
// tt_um_guihca_scope : registered add mode plus DEPTH-bit serial capture scope
// Optional build macro: GUIHCA_SYNC_EN (two-flop synchronizer on ui_in)
// Rev 1.0
// ============================================================================
`default_nettype none

module tt_um_guihca_scope #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter int          DEPTH     = 64
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int NBYTES = DEPTH / 8;
  localparam int KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CAPTURE  = 2'b01,
    PLAYBACK = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        ui_q, ui_d;
  logic              arm_dly_q, arm_dly_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic [23:0]       tick_q, tick_d;
  logic [DEPTH-1:0]  cap_q, cap_d;
  logic [7:0]        uo_q, uo_d;
  logic              arm_rise;
  logic [7:0]        cnt_byte;
  logic              unused_ok;

`ifdef GUIHCA_SYNC_EN
  logic [7:0] sync_q, sync_d;
  always_comb sync_d = ui_in;
  always_comb ui_d   = sync_q;
`else
  always_comb ui_d   = ui_in;
`endif

  assign arm_rise  = ui_q[1] & ~arm_dly_q;
  assign cnt_byte  = 8'(cnt_q);
  assign unused_ok = &{1'b0, uio_in[7:6]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    tick_d    = tick_q;
    cap_d     = cap_q;
    uo_d      = uo_q;
    arm_dly_d = ui_q[1];

    // Mode low overrides everything, which also swallows a coincident arm edge
    if (!ui_q[2]) begin
      state_d = IDLE;
      uo_d    = ui_q + {2'b00, uio_in[5:0]};
    end else begin
      case (state_q)
        IDLE: begin
          if (arm_rise) begin
            state_d = CAPTURE;
            cnt_d   = '0;
          end
        end
        CAPTURE: begin
          cap_d[cnt_q[AW-1:0]] = ui_q[0];
          cnt_d = cnt_q + 1'b1;
          uo_d  = cnt_byte;
          if (cnt_q == CW'(DEPTH - 1)) begin
            state_d = PLAYBACK;
            k_d     = '0;
            tick_d  = '0;
          end
        end
        PLAYBACK: begin
          uo_d = cap_q[{k_q, 3'b000} +: 8];
          if (tick_q == MAX_COUNT - 24'd1) begin
            tick_d = '0;
            k_d    = (k_q == KW'(NBYTES - 1)) ? '0 : k_q + 1'b1;
          end else begin
            tick_d = tick_q + 24'd1;
          end
          if (arm_rise) begin
            state_d = CAPTURE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ui_q      <= '0;
      arm_dly_q <= 1'b0;
      cnt_q     <= '0;
      k_q       <= '0;
      tick_q    <= '0;
      cap_q     <= '0;
      uo_q      <= '0;
`ifdef GUIHCA_SYNC_EN
      sync_q    <= '0;
`endif
    end else if (ena) begin
      state_q   <= state_d;
      ui_q      <= ui_d;
      arm_dly_q <= arm_dly_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      tick_q    <= tick_d;
      cap_q     <= cap_d;
      uo_q      <= uo_d;
`ifdef GUIHCA_SYNC_EN
      sync_q    <= sync_d;
`endif
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {state_q, 6'b000000};
  assign uio_oe  = 8'hC0;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_guihca_scope.sv
// ============================================================================
// tb_tt_um_guihca_scope : directed self-checking bench, DEPTH=16, MAX_COUNT=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tt_um_guihca_scope;

`ifdef GUIHCA_SYNC_EN
  localparam int SY = 1;
`else
  localparam int SY = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  tt_um_guihca_scope #(
    .MAX_COUNT(24'd4),
    .DEPTH    (16)
  ) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] stream;
    stream = 16'h0FA5;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    rst_n  = 1'b0;

    step(2);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hC0);
    rst_n = 1'b1;

    // add mode and latency
    ui_in = 8'h3A; uio_in = 8'h2F;
    step(1 + SY);
    check("add_lat", uo_out, 8'h2F);
    step(1);
    check("add_3a", uo_out, 8'h69);
    check("add_state", uio_out, 8'h00);
    ui_in = 8'hFA; uio_in = 8'h3F;
    step(2 + SY);
    check("add_wrap", uo_out, 8'h39);

    // scope mode idle holds the display
    ui_in = 8'h04; uio_in = 8'h00;
    step(3);
    check("idle_hold", uo_out, 8'hFA);
    check("idle_state", uio_out, 8'h00);

    // arm edge then 16-bit stream, LSB first
    ui_in = 8'h06;
    step(1);
    for (int i = 0; i < 16; i++) begin
      ui_in = 8'h06 | {7'd0, stream[i]};
      step(1);
      if (i >= SY) check($sformatf("cap_state%0d", i), uio_out, 8'h40);
      if (i >= 1 + SY) check($sformatf("cap_cnt%0d", i), uo_out, 8'(i - 1 - SY));
    end
    ui_in = 8'h06;
    step(1 + SY);
    check("cap_last_cnt", uo_out, 8'h0F);
    check("pb_state", uio_out, 8'h80);
    for (int j = 0; j < 4; j++) begin
      step(1);
      check($sformatf("pb_b0_%0d", j), uo_out, 8'hA5);
    end
    for (int j = 0; j < 4; j++) begin
      step(1);
      check($sformatf("pb_b1_%0d", j), uo_out, 8'h0F);
    end
    step(1);
    check("pb_kwrap", uo_out, 8'hA5);

    // enable low freezes playback mid-dwell
    ena = 1'b0;
    step(10);
    check("ena_uo", uo_out, 8'hA5);
    check("ena_state", uio_out, 8'h80);
    ena = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(1);
      check($sformatf("ena_dwell%0d", j), uo_out, 8'hA5);
    end
    step(1);
    check("ena_next", uo_out, 8'h0F);

    // re-arm during playback, arm toggles ignored during capture
    ui_in = 8'h04;
    step(2 + SY);
    ui_in = 8'h06;
    step(2 + SY);
    check("rearm_state", uio_out, 8'h40);
    ui_in = 8'h04;
    step(2);
    ui_in = 8'h06;
    step(2);
    check("rearm_toggle", uio_out, 8'h40);
    check("rearm_cnt", uo_out, 8'h03);
    step(11);
    check("rearm_still", uio_out, 8'h40);
    step(1);
    check("rearm_done", uio_out, 8'h80);
    check("rearm_cnt15", uo_out, 8'h0F);
    step(1);
    check("rearm_byte0", uo_out, 8'h00);

    // mode drop mid-playback
    ui_in = 8'h3A; uio_in = 8'h2F;
    step(1 + SY);
    check("drop_pre", uio_out, 8'h80);
    step(1);
    check("drop_state", uio_out, 8'h00);
    check("drop_add", uo_out, 8'h69);
    ui_in = 8'h06;
    step(4);
    check("remode_idle", uio_out, 8'h00);
    check("remode_hold", uo_out, 8'h69);

    // mode low together with arm edge: edge is consumed
    ui_in = 8'h04;
    step(2 + SY);
    ui_in = 8'h02;
    step(2 + SY);
    ui_in = 8'h06;
    step(4 + SY);
    check("modearm_state", uio_out, 8'h00);
    check("modearm_uo", uo_out, 8'h31);

    // asynchronous reset in the middle of a capture
    ui_in = 8'h04;
    step(2 + SY);
    ui_in = 8'h07;
    step(6 + SY);
    check("pre_rst_state", uio_out, 8'h40);
    check("pre_rst_cnt", uo_out, 8'h03);
    #1 rst_n = 1'b0;
    #1;
    check("arst_uo", uo_out, 8'h00);
    check("arst_uio", uio_out, 8'h00);
    check("arst_oe", uio_oe, 8'hC0);
    step(2);
    uio_in = 8'h00;
    ui_in  = 8'h04;
    rst_n  = 1'b1;
    step(3);
    check("post_rst_state", uio_out, 8'h00);
    check("post_rst_uo", uo_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
